// File: rtl/fwd_hazard_unit_pkg.sv
// mips_pipe_pkg: shared stage-entry type and helpers
// for the forwarding/hazard unit.
package mips_pipe_pkg;

    localparam int PIPE_AW   = 5;
    localparam int PIPE_NSRC = 2;
    localparam int FWD_RF    = 0;

    typedef struct packed {
        logic                                valid;
        logic [PIPE_AW-1:0]                  rd;
        logic                                regwrite;
        logic                                is_load;
        logic [PIPE_NSRC-1:0][PIPE_AW-1:0]   src;
        logic [PIPE_NSRC-1:0]                src_use;
    } stage_t;

    function automatic int sel_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // r0 is hardwired, so it never produces a match.
    function automatic logic tag_match(
        input stage_t             e,
        input logic [PIPE_AW-1:0] r,
        input logic               u
    );
        return e.valid && e.regwrite && (e.rd != '0)
            && (e.rd == r) && u;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-side request and stall/forward
// response bundle of the hazard unit.
interface fwd_hazard_unit_if
    import mips_pipe_pkg::*;
#(
    parameter int AW      = PIPE_AW,
    parameter int NUM_SRC = PIPE_NSRC,
    parameter int SEL_W   = 2
);
    logic                     id_valid;
    logic [NUM_SRC*AW-1:0]    id_rs;
    logic [NUM_SRC-1:0]       id_src_use;
    logic [AW-1:0]            id_rd;
    logic                     id_regwrite;
    logic                     id_is_load;
    logic                     id_is_md;
    logic                     flush;
    logic                     stall;
    logic                     bubble;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     md_busy;

    modport master (
        output id_valid, id_rs, id_src_use, id_rd,
        output id_regwrite, id_is_load, id_is_md, flush,
        input  stall, bubble, fwd_sel, md_busy
    );

    modport slave (
        input  id_valid, id_rs, id_src_use, id_rd,
        input  id_regwrite, id_is_load, id_is_md, flush,
        output stall, bubble, fwd_sel, md_busy
    );
endinterface

// File: rtl/fwd_hazard_unit_md_scoreboard.sv
// md_scoreboard: tracks the outstanding mul/div result and
// flags ID instructions that must wait for it.
module md_scoreboard #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int MD_LAT  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [AW-1:0]               rd_i,
    input  logic [NUM_SRC-1:0][AW-1:0]  rs_i,
    input  logic [NUM_SRC-1:0]          use_i,
    input  logic                        is_md_i,
    output logic                        busy_o,
    output logic                        hazard_o
);
    localparam int CW = $clog2(MD_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          src_hit;

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        if (start_i) begin
            cnt_d = CW'(MD_LAT);
            rd_d  = rd_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (use_i[i] && (rs_i[i] == rd_q))
                src_hit = 1'b1;
        end
    end

    // The final busy cycle (count of 1) still blocks.
    assign busy_o   = (cnt_q != '0);
    assign hazard_o = busy_o
        && (is_md_i || (src_hit && (rd_q != '0)));

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: destination-tag pipeline from EX onward,
// EX forwarding selects and load-use / mul-div stalls.
module fwd_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int AW         = PIPE_AW,
    parameter int NUM_SRC    = PIPE_NSRC,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 2,
    parameter int MD_LAT     = 4,
    parameter int SEL_W      = sel_w(FWD_DEPTH)
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);
    stage_t [FWD_DEPTH:0]          stg_q, stg_d;
    stage_t                        id_ent;
    logic [NUM_SRC-1:0][SEL_W-1:0] sel;
    logic                          load_use;
    logic                          md_haz;
    logic                          md_busy;
    logic                          hold;
    logic                          issue;

    // Mul/div results come from the md unit, never the tags.
    always_comb begin
        id_ent          = '0;
        id_ent.valid    = 1'b1;
        id_ent.rd       = bus.id_rd;
        id_ent.regwrite = bus.id_regwrite && !bus.id_is_md;
        id_ent.is_load  = bus.id_is_load;
        id_ent.src      = bus.id_rs;
        id_ent.src_use  = bus.id_src_use;
    end

    always_comb begin
        load_use = 1'b0;
        for (int s = 0; s <= FWD_DEPTH; s++) begin
            if ((s + 1 < LOAD_READY) && stg_q[s].is_load) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (tag_match(stg_q[s], id_ent.src[i],
                                  id_ent.src_use[i]))
                        load_use = 1'b1;
                end
            end
        end
    end

    md_scoreboard #(
        .AW      (AW),
        .NUM_SRC (NUM_SRC),
        .MD_LAT  (MD_LAT)
    ) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (issue && bus.id_is_md),
        .rd_i     (bus.id_rd),
        .rs_i     (bus.id_rs),
        .use_i    (bus.id_src_use),
        .is_md_i  (bus.id_is_md),
        .busy_o   (md_busy),
        .hazard_o (md_haz)
    );

    // Flush wins over any hazard.
    assign hold  = bus.id_valid && !bus.flush
                && (load_use || md_haz);
    assign issue = bus.id_valid && !bus.flush && !hold;

    always_comb begin
        stg_d    = '0;
        stg_d[0] = issue ? id_ent : '0;
        for (int k = 1; k <= FWD_DEPTH; k++)
            stg_d[k] = stg_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stg_q <= '0;
        else
            stg_q <= stg_d;
    end

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel[i] = SEL_W'(FWD_RF);
            if (stg_q[0].valid) begin
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    if (tag_match(stg_q[k], stg_q[0].src[i],
                                  stg_q[0].src_use[i]))
                        sel[i] = SEL_W'(k);
                end
            end
        end
    end

    assign bus.stall   = hold;
    assign bus.bubble  = hold;
    assign bus.fwd_sel = sel;
    assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios plus random traffic
// against an instruction-history reference model.
module tb_fwd_hazard_unit;
    localparam int AW = 5, NS = 2, FD = 2, LR = 2, ML = 4, SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fwd_hazard_unit_if #(.AW(AW), .NUM_SRC(NS), .SEL_W(SW)) bus();

    fwd_hazard_unit #(
        .AW(AW), .NUM_SRC(NS), .FWD_DEPTH(FD),
        .LOAD_READY(LR), .MD_LAT(ML), .SEL_W(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit            v;
        bit [4:0]      rd;
        bit            wr;
        bit            ld;
        bit            md;
        bit [1:0][4:0] rs;
        bit [1:0]      u;
    } ins_t;

    // hist[k] = instruction that entered EX k edges ago.
    ins_t     hist[$];
    ins_t     cur;
    bit       cur_fl;
    int       md_age = -1;
    bit [4:0] md_rd_m = 5'd0;

    function automatic ins_t stage(int k);
        if (k < hist.size()) return hist[k];
        return '0;
    endfunction

    function automatic bit m_busy();
        return (md_age >= 0) && (md_age < ML);
    endfunction

    function automatic bit m_hold();
        ins_t e;
        if (!cur.v || cur_fl) return 1'b0;
        for (int s = 0; s <= FD; s++) begin
            e = stage(s);
            if (s + 1 < LR && e.v && e.ld && e.wr && e.rd != 0)
                for (int i = 0; i < NS; i++)
                    if (cur.u[i] && cur.rs[i] == e.rd) return 1'b1;
        end
        if (m_busy()) begin
            if (cur.md) return 1'b1;
            for (int i = 0; i < NS; i++)
                if (cur.u[i] && md_rd_m != 0 && cur.rs[i] == md_rd_m)
                    return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_fwd(int i);
        ins_t ex, e;
        ex = stage(0);
        if (!ex.v || !ex.u[i]) return 0;
        for (int k = 1; k <= FD; k++) begin
            e = stage(k);
            if (e.v && e.wr && e.rd != 0 && e.rd == ex.rs[i]) return k;
        end
        return 0;
    endfunction

    function automatic bit [3:0] m_sel();
        return {2'(m_fwd(1)), 2'(m_fwd(0))};
    endfunction

    task automatic model_reset();
        hist.delete();
        md_age  = -1;
        md_rd_m = 5'd0;
    endtask

    task automatic set_id(bit v, bit [4:0] rd, bit wr, bit ld, bit md,
                          bit [4:0] s0, bit [4:0] s1, bit [1:0] u, bit fl);
        cur.v = v; cur.rd = rd; cur.wr = wr; cur.ld = ld; cur.md = md;
        cur.rs[0] = s0; cur.rs[1] = s1; cur.u = u; cur_fl = fl;
        bus.id_valid = v; bus.id_rd = rd; bus.id_regwrite = wr;
        bus.id_is_load = ld; bus.id_is_md = md;
        bus.id_rs = {s1, s0}; bus.id_src_use = u; bus.flush = fl;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        ins_t e;
        e = '0;
        if (cur.v && !cur_fl && !m_hold()) begin
            e = cur;
            e.wr = cur.wr && !cur.md;
        end
        hist.push_front(e);
        while (hist.size() > FD + 1) void'(hist.pop_back());
        if (md_age >= 0) md_age++;
        if (e.v && e.md) begin
            md_age  = 0;
            md_rd_m = e.rd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 2'b11, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %0b want 0", bus.stall); end
        checks++; if (bus.bubble !== 1'b0) begin errors++;
            $display("FAIL reset_bubble: got %0b want 0", bus.bubble); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++;
            $display("FAIL reset_md_busy: got %0b want 0", bus.md_busy); end
        checks++; if (bus.fwd_sel !== 4'h0) begin errors++;
            $display("FAIL reset_fwd: got %0h want 0", bus.fwd_sel); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL b2b_stall: got %0b want 0", bus.stall); end
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h5) begin errors++;
            $display("FAIL b2b_fwd: got %0h want 5", bus.fwd_sel); end
        tick();
    endtask

    task automatic test_youngest();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd3, 5'd6, 2'b11, 1'b0);
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h2) begin errors++;
            $display("FAIL gap_fwd: got %0h want 2", bus.fwd_sel); end
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd3, 5'd6, 2'b11, 1'b0);
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h1) begin errors++;
            $display("FAIL youngest_fwd: got %0h want 1", bus.fwd_sel); end
        tick();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b1) begin errors++;
            $display("FAIL lu_stall: got %0b want 1", bus.stall); end
        checks++; if (bus.bubble !== 1'b1) begin errors++;
            $display("FAIL lu_bubble: got %0b want 1", bus.bubble); end
        tick();
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL lu_release: got %0b want 0", bus.stall); end
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'hA) begin errors++;
            $display("FAIL lu_fwd: got %0h want a", bus.fwd_sel); end
        tick();
    endtask

    task automatic test_muldiv();
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL md_issue: got %0b want 0", bus.stall); end
        tick();
        for (int c = 0; c < ML; c++) begin
            set_id(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd9, 5'd1, 2'b11, 1'b0);
            checks++; if (bus.stall !== 1'b1) begin errors++;
                $display("FAIL md_stall[%0d]: got %0b want 1", c, bus.stall); end
            checks++; if (bus.md_busy !== 1'b1) begin errors++;
                $display("FAIL md_busy[%0d]: got %0b want 1", c, bus.md_busy); end
            tick();
        end
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd9, 5'd1, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL md_release: got %0b want 0", bus.stall); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++;
            $display("FAIL md_idle: got %0b want 0", bus.md_busy); end
        tick();
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL md_indep: got %0b want 0", bus.stall); end
        checks++; if (bus.md_busy !== 1'b1) begin errors++;
            $display("FAIL md_indep_busy: got %0b want 1", bus.md_busy); end
        tick();
        set_id(1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b1) begin errors++;
            $display("FAIL md_md: got %0b want 1", bus.stall); end
        nop();
        repeat (ML) tick();
    endtask

    task automatic test_r0_flush();
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0);
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h0) begin errors++;
            $display("FAIL r0_fwd: got %0h want 0", bus.fwd_sel); end
        set_id(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL r0_load: got %0b want 0", bus.stall); end
        tick();
        set_id(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd6, 5'd6, 2'b11, 1'b0);
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h0) begin errors++;
            $display("FAIL nowr_fwd: got %0h want 0", bus.fwd_sel); end
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 2'b11, 1'b1);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL flush_stall: got %0b want 0", bus.stall); end
        checks++; if (bus.bubble !== 1'b0) begin errors++;
            $display("FAIL flush_bubble: got %0b want 0", bus.bubble); end
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h0) begin errors++;
            $display("FAIL flush_ex: got %0h want 0", bus.fwd_sel); end
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);
        tick();
        set_id(1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL invalid_id: got %0b want 0", bus.stall); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 2'b11, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd9, 5'd9, 2'b11, 1'b0);
        checks++; if (bus.stall !== 1'b1) begin errors++;
            $display("FAIL pre_rst_stall: got %0b want 1", bus.stall); end
        checks++; if (bus.fwd_sel !== 4'h5) begin errors++;
            $display("FAIL pre_rst_fwd: got %0h want 5", bus.fwd_sel); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL mid_rst_stall: got %0b want 0", bus.stall); end
        checks++; if (bus.md_busy !== 1'b0) begin errors++;
            $display("FAIL mid_rst_busy: got %0b want 0", bus.md_busy); end
        checks++; if (bus.fwd_sel !== 4'h0) begin errors++;
            $display("FAIL mid_rst_fwd: got %0h want 0", bus.fwd_sel); end
        #2;
        rst_n = 1'b1;
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd4, 5'd3, 2'b11, 1'b0);
        tick();
        nop();
        checks++; if (bus.fwd_sel !== 4'h0) begin errors++;
            $display("FAIL post_rst_fwd: got %0h want 0", bus.fwd_sel); end
        tick();
    endtask

    task automatic test_random();
        bit       v, wr, ld, md, fl, hx, bx;
        bit [3:0] sx;
        int       kind;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 19));
            v  = ($urandom_range(0, 9) < 8);
            md = (kind == 0);
            ld = (kind >= 1 && kind <= 4);
            wr = ld || (kind < 18);
            fl = ($urandom_range(0, 9) == 0);
            set_id(v, 5'($urandom_range(0, 7)), wr, ld, md,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), fl);
            hx = m_hold();
            bx = m_busy();
            sx = m_sel();
            checks++; if (bus.stall !== hx) begin errors++;
                $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, bus.stall, hx); end
            checks++; if (bus.bubble !== hx) begin errors++;
                $display("FAIL rnd_bubble[%0d]: got %0b want %0b", n, bus.bubble, hx); end
            checks++; if (bus.md_busy !== bx) begin errors++;
                $display("FAIL rnd_busy[%0d]: got %0b want %0b", n, bus.md_busy, bx); end
            checks++; if (bus.fwd_sel !== sx) begin errors++;
                $display("FAIL rnd_fwd[%0d]: got %0h want %0h", n, bus.fwd_sel, sx); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_youngest();
        test_load_use();
        test_muldiv();
        test_r0_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
